// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_sequencer
// Brief    : Two-phase fetch/execute controller for the nibble ALU/accumulator
//            datapath, with registered carry/zero flags for conditional jumps.
// Revision : 1.0 - initial release
// ============================================================================
module alu_sequencer #(
    parameter bit       AUTO_START  = 1'b0,
    parameter bit [3:0] HALT_OPCODE = 4'hF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] program_byte,
    input  logic       carry_in,
    input  logic       zero_in,
    output logic       enableA,
    output logic       enableB1,
    output logic       enableB2,
    output logic [2:0] F,
    output logic [3:0] oprnd,
    output logic       pc_inc,
    output logic       pc_load,
    output logic       c_flag,
    output logic       z_flag,
    output logic [1:0] state,
    output logic       halted
);

    localparam logic [1:0] c_idle  = 2'b00;
    localparam logic [1:0] c_fetch = 2'b01;
    localparam logic [1:0] c_exec  = 2'b10;
    localparam logic [1:0] c_halt  = 2'b11;

    localparam logic [2:0] c_f_acc  = 3'b000;
    localparam logic [2:0] c_f_sub  = 3'b001;
    localparam logic [2:0] c_f_b    = 3'b010;
    localparam logic [2:0] c_f_add  = 3'b011;
    localparam logic [2:0] c_f_nand = 3'b100;

    logic [1:0] r_state;
    logic [1:0] w_state_next;
    logic [7:0] r_ir;
    logic       r_c;
    logic       r_z;
    logic [3:0] w_opcode;
    logic       w_is_halt;
    logic       w_flag_op;

    assign w_opcode  = r_ir[7:4];
    assign w_is_halt = (w_opcode == HALT_OPCODE);
    // Halt decode wins so a HALT_OPCODE overlapping an ALU op never touches flags.
    assign w_flag_op = !w_is_halt &&
                       ((w_opcode == 4'h2) || (w_opcode == 4'h3) ||
                        (w_opcode == 4'h4) || (w_opcode == 4'h6));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= AUTO_START ? c_fetch : c_idle;
            r_ir    <= 8'h00;
            r_c     <= 1'b0;
            r_z     <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (r_state == c_fetch) begin
                r_ir <= program_byte;
            end
            if ((r_state == c_exec) && w_flag_op) begin
                r_c <= carry_in;
                r_z <= zero_in;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_idle:  if (start) w_state_next = c_fetch;
            c_fetch: w_state_next = c_exec;
            c_exec:  w_state_next = w_is_halt ? c_halt : c_fetch;
            default: w_state_next = c_halt;
        endcase
    end

    always_comb begin
        enableA  = 1'b0;
        enableB1 = 1'b0;
        enableB2 = 1'b0;
        F        = c_f_acc;
        pc_inc   = 1'b0;
        pc_load  = 1'b0;
        if (r_state == c_fetch) begin
            pc_inc = 1'b1;
        end else if ((r_state == c_exec) && !w_is_halt) begin
            case (w_opcode)
                4'h1: begin F = c_f_b;    enableB1 = 1'b1; enableA = 1'b1; end
                4'h2: begin F = c_f_add;  enableB1 = 1'b1; enableA = 1'b1; end
                4'h3: begin F = c_f_sub;  enableB1 = 1'b1; enableA = 1'b1; end
                4'h4: begin F = c_f_nand; enableB1 = 1'b1; enableA = 1'b1; end
                4'h5: begin F = c_f_acc;  enableB2 = 1'b1; end
                4'h6: begin F = c_f_sub;  enableB1 = 1'b1; end
                4'h7: pc_load = 1'b1;
                4'h8: pc_load = r_c;
                4'h9: pc_load = !r_c;
                4'hA: pc_load = r_z;
                4'hB: pc_load = !r_z;
                default: ;
            endcase
        end
    end

    assign oprnd  = r_ir[3:0];
    assign c_flag = r_c;
    assign z_flag = r_z;
    assign state  = r_state;
    assign halted = (r_state == c_halt);

endmodule
`default_nettype wire

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Two-phase fetch/execute controller for the nibble ALU/accumulator datapath: operand bus buffer, ALU with 3-bit function select, accumulator, output buffer.
- Latches an 8-bit instruction (opcode[7:4], operand[3:0]) from program memory.
- Drives the datapath control lines (enableA, enableB1, enableB2, F, oprnd) and the program-counter controls.
- Keeps registered carry/zero flags for conditional jumps.

Parameters:
- AUTO_START, 0, 1 = leave reset directly into FETCH; 0 = wait in IDLE for start.
- HALT_OPCODE, 4'hF, opcode that moves the FSM to HALT.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  leaves IDLE; sampled only in IDLE.
- program_byte  in  8  instruction at current PC, valid during FETCH.
- carry_in  in  1  ALU CARRY output.
- zero_in  in  1  ALU ZERO output.
- enableA  out  1  accumulator load enable.
- enableB1  out  1  operand bus-buffer enable.
- enableB2  out  1  output bus-buffer enable.
- F  out  3  ALU function: 000 pass ACC, 001 ACC-B, 010 pass B, 011 ACC+B, 100 NAND.
- oprnd  out  4  IR[3:0]; datapath operand and jump target.
- pc_inc  out  1  PC increment strobe.
- pc_load  out  1  PC load strobe (load value = oprnd).
- c_flag  out  1  registered carry flag.
- z_flag  out  1  registered zero flag.
- state  out  2  00 IDLE, 01 FETCH, 10 EXEC, 11 HALT.
- halted  out  1  high in HALT.

Behaviour:
- Reset (synchronous, priority over everything; also mid-instruction):
  - state = IDLE, or FETCH if AUTO_START=1.
  - IR = 8'h00, c_flag = 0, z_flag = 0.
  - All control outputs 0; F = 000.
- Control outputs are decoded from state and IR only; no combinational path from start, program_byte or flag inputs.
- IDLE: all controls 0; start=1 -> FETCH next cycle.
- FETCH (1 cycle):
  - pc_inc = 1.
  - IR <= program_byte at the closing edge.
  - -> EXEC.
- EXEC (1 cycle), by opcode. Datapath registers and flags capture at the closing edge.
  - 0 NOP: nothing.
  - 1 LIT: F=010, enableB1=1, enableA=1.
  - 2 ADD: F=011, enableB1=1, enableA=1, flags update.
  - 3 SUB: F=001, enableB1=1, enableA=1, flags update.
  - 4 NAND: F=100, enableB1=1, enableA=1, flags update.
  - 5 OUT: F=000, enableB2=1.
  - 6 CMP: F=001, enableB1=1, enableA=0, flags update.
  - 7 JMP: pc_load=1.
  - 8 JC / 9 JNC: pc_load = c_flag / !c_flag.
  - A JZ / B JNZ: pc_load = z_flag / !z_flag.
  - HALT_OPCODE: no controls; -> HALT.
  - Any other opcode: NOP.
  - Non-halt -> FETCH.
- Flag update: c_flag <= carry_in and z_flag <= zero_in, only at the EXEC closing edge of ADD/SUB/NAND/CMP. Otherwise flags hold.
- Jump conditions use the registered flags, i.e. the result of the most recent flag-updating instruction.
- pc_inc and pc_load are never high together.
- pc_inc is never high outside FETCH.
- Throughput: fixed 2 cycles per instruction; a taken jump costs no extra cycle.
- HALT: all controls 0, halted=1; stays until reset. start is ignored.
- start is ignored in FETCH and EXEC.
- enableA only ever asserts together with enableB1 (operand-sourced ops).
- IR and flags never change in IDLE or HALT.

Test Plan:
- Reset mid-EXEC of ADD (enableA=1) -> next cycle state=00, all controls 0, flags 0, IR=00. With AUTO_START=1, state=01 instead.
- start=1 in IDLE; program 0x1A then 0x5x -> LIT EXEC: F=010, B1=1, A=1, oprnd=1010. OUT EXEC: F=000, B2=1. pc_inc seen on exactly 2 FETCH cycles.
- ADD 0x2F with carry_in=1, zero_in=1 at EXEC -> c_flag=1, z_flag=1 after the edge. Following LIT leaves both flags unchanged.
- CMP 0x61 -> enableA stays 0; flags take carry_in/zero_in.
- Conditional jumps:
  - JZ 0xA3 with z_flag=1 -> pc_load=1, oprnd=0011.
  - JNZ 0xB3 -> pc_load=0.
  - JC with c_flag=0 -> pc_load=0.
  - JNC -> pc_load=1.
- 0xF0 -> state=11, halted=1 from the next cycle. Pulsing start and changing program_byte for 5 cycles has no effect; reset returns to IDLE.
- Unused opcodes C, D, E -> behave as NOP: all enables 0, 2-cycle progression continues.
